// File: rtl/ibex_wb_queue_if.sv
// Writeback queue bus: ID/EX offer, LSU response, RF write and hazard signals.
// The master modport is the ID/EX + LSU side; the slave modport is the queue.
package ibex_wb_queue_pkg;
    typedef enum logic [1:0] {
        WB_INSTR_LOAD  = 2'b00,
        WB_INSTR_STORE = 2'b01,
        WB_INSTR_OTHER = 2'b10
    } wb_instr_type_e;
endpackage

interface ibex_wb_queue_if #(
    parameter int Depth = 2
);
    import ibex_wb_queue_pkg::*;

    localparam int CntW = $clog2(Depth + 1);

    logic                en_wb_i;
    wb_instr_type_e      instr_type_wb_i;
    logic [31:0]         pc_id_i;
    logic                instr_is_compressed_id_i;
    logic                instr_perf_count_id_i;
    logic [4:0]          rf_waddr_id_i;
    logic [31:0]         rf_wdata_id_i;
    logic                rf_we_id_i;
    logic                dummy_instr_id_i;
    logic [4:0]          rf_raddr_a_i;
    logic [4:0]          rf_raddr_b_i;
    logic [31:0]         rf_wdata_lsu_i;
    logic                rf_we_lsu_i;
    logic                lsu_resp_valid_i;
    logic                lsu_resp_err_i;

    logic                ready_wb_o;
    logic [4:0]          rf_waddr_wb_o;
    logic [31:0]         rf_wdata_wb_o;
    logic                rf_we_wb_o;
    logic                fwd_a_valid_o;
    logic                fwd_b_valid_o;
    logic [31:0]         fwd_a_data_o;
    logic [31:0]         fwd_b_data_o;
    logic                stall_a_o;
    logic                stall_b_o;
    logic                outstanding_load_wb_o;
    logic                outstanding_store_wb_o;
    logic [CntW-1:0]     occupancy_o;
    logic [31:0]         pc_wb_o;
    logic                instr_done_wb_o;
    logic                perf_instr_ret_wb_o;
    logic                perf_instr_ret_compressed_wb_o;
    logic                lsu_resp_unexpected_o;
    logic                dummy_instr_wb_o;

    modport master (
        output en_wb_i, instr_type_wb_i, pc_id_i, instr_is_compressed_id_i,
               instr_perf_count_id_i, rf_waddr_id_i, rf_wdata_id_i, rf_we_id_i,
               dummy_instr_id_i, rf_raddr_a_i, rf_raddr_b_i, rf_wdata_lsu_i,
               rf_we_lsu_i, lsu_resp_valid_i, lsu_resp_err_i,
        input  ready_wb_o, rf_waddr_wb_o, rf_wdata_wb_o, rf_we_wb_o,
               fwd_a_valid_o, fwd_b_valid_o, fwd_a_data_o, fwd_b_data_o,
               stall_a_o, stall_b_o, outstanding_load_wb_o, outstanding_store_wb_o,
               occupancy_o, pc_wb_o, instr_done_wb_o, perf_instr_ret_wb_o,
               perf_instr_ret_compressed_wb_o, lsu_resp_unexpected_o, dummy_instr_wb_o
    );

    modport slave (
        input  en_wb_i, instr_type_wb_i, pc_id_i, instr_is_compressed_id_i,
               instr_perf_count_id_i, rf_waddr_id_i, rf_wdata_id_i, rf_we_id_i,
               dummy_instr_id_i, rf_raddr_a_i, rf_raddr_b_i, rf_wdata_lsu_i,
               rf_we_lsu_i, lsu_resp_valid_i, lsu_resp_err_i,
        output ready_wb_o, rf_waddr_wb_o, rf_wdata_wb_o, rf_we_wb_o,
               fwd_a_valid_o, fwd_b_valid_o, fwd_a_data_o, fwd_b_data_o,
               stall_a_o, stall_b_o, outstanding_load_wb_o, outstanding_store_wb_o,
               occupancy_o, pc_wb_o, instr_done_wb_o, perf_instr_ret_wb_o,
               perf_instr_ret_compressed_wb_o, lsu_resp_unexpected_o, dummy_instr_wb_o
    );
endinterface

// File: rtl/ibex_wb_queue.sv
// In-order multi-entry writeback queue with per-operand forwarding/stall lookup.
// Optional dummy-instruction tracking is enabled by defining IBEX_WB_QUEUE_DUMMY_EN.
module ibex_wb_queue
    import ibex_wb_queue_pkg::*;
#(
    parameter int Depth = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    ibex_wb_queue_if.slave        bus
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    typedef struct packed {
        logic           we;
        logic [4:0]     waddr;
        logic [31:0]    wdata;
        wb_instr_type_e typ;
        logic [31:0]    pc;
        logic           compressed;
        logic           perf_count;
    } entry_t;

    entry_t            ent_reg [Depth];
    logic [PtrW-1:0]   head_reg;
    logic [PtrW-1:0]   tail_reg;
    logic [CntW-1:0]   count_reg;

    entry_t            head_ent;
    logic              head_valid;
    logic              head_done;
    logic              ready;
    logic              accept;
    logic              head_dummy;
    logic              we_id_path;
    logic              we_lsu_path;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(Depth - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign head_ent   = ent_reg[head_reg];
    assign head_valid = (count_reg != '0);
    assign head_done  = head_valid & ((head_ent.typ == WB_INSTR_OTHER) | bus.lsu_resp_valid_i);
    assign ready      = (count_reg < CntW'(Depth)) | head_done;
    assign accept     = bus.en_wb_i & ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            for (int i = 0; i < Depth; i++) begin
                ent_reg[i] <= '0;
            end
        end else begin
            if (accept) begin
                ent_reg[tail_reg].we         <= bus.rf_we_id_i;
                ent_reg[tail_reg].waddr      <= bus.rf_waddr_id_i;
                ent_reg[tail_reg].wdata      <= bus.rf_wdata_id_i;
                ent_reg[tail_reg].typ        <= bus.instr_type_wb_i;
                ent_reg[tail_reg].pc         <= bus.pc_id_i;
                ent_reg[tail_reg].compressed <= bus.instr_is_compressed_id_i;
                ent_reg[tail_reg].perf_count <= bus.instr_perf_count_id_i;
                tail_reg                     <= ptr_inc(tail_reg);
            end
            if (head_done) begin
                head_reg <= ptr_inc(head_reg);
            end
            if (accept && !head_done) begin
                count_reg <= count_reg + 1'b1;
            end else if (!accept && head_done) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

`ifdef IBEX_WB_QUEUE_DUMMY_EN
    logic dummy_reg [Depth];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                dummy_reg[i] <= 1'b0;
            end
        end else if (accept) begin
            dummy_reg[tail_reg] <= bus.dummy_instr_id_i;
        end
    end

    assign head_dummy = head_valid & dummy_reg[head_reg];
`else
    logic unused_dummy;
    assign unused_dummy = bus.dummy_instr_id_i;
    assign head_dummy   = 1'b0;
`endif

    // Map age (0 = oldest) to physical slot; handles non-power-of-2 wrap.
    logic [Depth-1:0][PtrW-1:0] age_slot;
    logic [Depth-1:0]           age_valid;

    genvar gi;
    for (gi = 0; gi < Depth; gi++) begin : g_age
        logic [PtrW:0] sum;
        assign sum           = {1'b0, head_reg} + (PtrW+1)'(gi);
        assign age_slot[gi]  = (sum >= (PtrW+1)'(Depth)) ? PtrW'(sum - (PtrW+1)'(Depth))
                                                         : sum[PtrW-1:0];
        assign age_valid[gi] = (CntW'(gi) < count_reg);
    end

    // Oldest first, so a younger matching entry overrides an older one.
    for (gi = 0; gi < 2; gi++) begin : g_hazard
        logic [4:0]  raddr;
        logic        fwd_valid;
        logic [31:0] fwd_data;
        logic        stall;

        assign raddr = (gi == 0) ? bus.rf_raddr_a_i : bus.rf_raddr_b_i;

        always_comb begin
            fwd_valid = 1'b0;
            fwd_data  = '0;
            stall     = 1'b0;
            for (int k = 0; k < Depth; k++) begin
                if (age_valid[k] && (raddr != 5'd0) &&
                    (ent_reg[age_slot[k]].waddr == raddr) &&
                    (ent_reg[age_slot[k]].we || (ent_reg[age_slot[k]].typ == WB_INSTR_LOAD))) begin
                    if (ent_reg[age_slot[k]].typ == WB_INSTR_LOAD) begin
                        stall     = 1'b1;
                        fwd_valid = 1'b0;
                        fwd_data  = '0;
                    end else begin
                        stall     = 1'b0;
                        fwd_valid = 1'b1;
                        fwd_data  = ent_reg[age_slot[k]].wdata;
                    end
                end
            end
        end
    end

    logic outstanding_load;
    logic outstanding_store;

    always_comb begin
        outstanding_load  = 1'b0;
        outstanding_store = 1'b0;
        for (int k = 0; k < Depth; k++) begin
            if (age_valid[k] && ent_reg[age_slot[k]].typ == WB_INSTR_LOAD) begin
                outstanding_load = 1'b1;
            end
            if (age_valid[k] && ent_reg[age_slot[k]].typ == WB_INSTR_STORE) begin
                outstanding_store = 1'b1;
            end
        end
    end

    assign we_id_path  = head_valid & head_ent.we & (head_ent.typ == WB_INSTR_OTHER);
    assign we_lsu_path = head_valid & (head_ent.typ == WB_INSTR_LOAD) & bus.rf_we_lsu_i;

    assign bus.ready_wb_o             = ready;
    assign bus.rf_we_wb_o             = we_id_path | we_lsu_path;
    assign bus.rf_waddr_wb_o          = head_ent.waddr;
    assign bus.rf_wdata_wb_o          = ({32{we_id_path}}  & head_ent.wdata) |
                                        ({32{we_lsu_path}} & bus.rf_wdata_lsu_i);
    assign bus.fwd_a_valid_o          = g_hazard[0].fwd_valid;
    assign bus.fwd_a_data_o           = g_hazard[0].fwd_data;
    assign bus.stall_a_o              = g_hazard[0].stall;
    assign bus.fwd_b_valid_o          = g_hazard[1].fwd_valid;
    assign bus.fwd_b_data_o           = g_hazard[1].fwd_data;
    assign bus.stall_b_o              = g_hazard[1].stall;
    assign bus.outstanding_load_wb_o  = outstanding_load;
    assign bus.outstanding_store_wb_o = outstanding_store;
    assign bus.occupancy_o            = count_reg;
    assign bus.pc_wb_o                = head_ent.pc;
    assign bus.instr_done_wb_o        = head_done;
    assign bus.perf_instr_ret_wb_o    = head_done & head_ent.perf_count & ~head_dummy &
                                        ~(bus.lsu_resp_valid_i & bus.lsu_resp_err_i);
    assign bus.perf_instr_ret_compressed_wb_o = bus.perf_instr_ret_wb_o & head_ent.compressed;
    assign bus.lsu_resp_unexpected_o  = bus.lsu_resp_valid_i &
                                        ~(head_valid & (head_ent.typ != WB_INSTR_OTHER));
    assign bus.dummy_instr_wb_o       = head_dummy;

endmodule

// File: tb/tb_ibex_wb_queue.sv
// Drives a Depth=2 and a Depth=3 queue with identical stimulus and checks both
// against a queue-based reference model.
module tb_ibex_wb_queue;
    import ibex_wb_queue_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    ibex_wb_queue_if #(.Depth(2)) bus2();
    ibex_wb_queue_if #(.Depth(3)) bus3();

    ibex_wb_queue #(.Depth(2)) dut2 (.clk_i(clk), .rst_ni(rst_n), .bus(bus2.slave));
    ibex_wb_queue #(.Depth(3)) dut3 (.clk_i(clk), .rst_ni(rst_n), .bus(bus3.slave));

    logic           en, we, comp, cnt, dmy, lsu_we, resp, err;
    wb_instr_type_e itype;
    logic [31:0]    pc, wdata, lsu_data;
    logic [4:0]     waddr, ra, rb;

    assign bus2.en_wb_i = en;                   assign bus3.en_wb_i = en;
    assign bus2.instr_type_wb_i = itype;        assign bus3.instr_type_wb_i = itype;
    assign bus2.pc_id_i = pc;                   assign bus3.pc_id_i = pc;
    assign bus2.instr_is_compressed_id_i = comp; assign bus3.instr_is_compressed_id_i = comp;
    assign bus2.instr_perf_count_id_i = cnt;    assign bus3.instr_perf_count_id_i = cnt;
    assign bus2.rf_waddr_id_i = waddr;          assign bus3.rf_waddr_id_i = waddr;
    assign bus2.rf_wdata_id_i = wdata;          assign bus3.rf_wdata_id_i = wdata;
    assign bus2.rf_we_id_i = we;                assign bus3.rf_we_id_i = we;
    assign bus2.dummy_instr_id_i = dmy;         assign bus3.dummy_instr_id_i = dmy;
    assign bus2.rf_raddr_a_i = ra;              assign bus3.rf_raddr_a_i = ra;
    assign bus2.rf_raddr_b_i = rb;              assign bus3.rf_raddr_b_i = rb;
    assign bus2.rf_wdata_lsu_i = lsu_data;      assign bus3.rf_wdata_lsu_i = lsu_data;
    assign bus2.rf_we_lsu_i = lsu_we;           assign bus3.rf_we_lsu_i = lsu_we;
    assign bus2.lsu_resp_valid_i = resp;        assign bus3.lsu_resp_valid_i = resp;
    assign bus2.lsu_resp_err_i = err;           assign bus3.lsu_resp_err_i = err;

    typedef struct packed {
        logic        ready, we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        fav;
        logic [31:0] fad;
        logic        sa, fbv;
        logic [31:0] fbd;
        logic        sb, ol, os;
        logic [3:0]  occ;
        logic [31:0] pc;
        logic        done, perf, perfc, unexp, dummy;
    } obs_t;

    obs_t obs2, obs3;
    assign obs2 = {bus2.ready_wb_o, bus2.rf_we_wb_o, bus2.rf_waddr_wb_o, bus2.rf_wdata_wb_o,
                   bus2.fwd_a_valid_o, bus2.fwd_a_data_o, bus2.stall_a_o, bus2.fwd_b_valid_o,
                   bus2.fwd_b_data_o, bus2.stall_b_o, bus2.outstanding_load_wb_o,
                   bus2.outstanding_store_wb_o, 2'b00, bus2.occupancy_o, bus2.pc_wb_o,
                   bus2.instr_done_wb_o, bus2.perf_instr_ret_wb_o,
                   bus2.perf_instr_ret_compressed_wb_o, bus2.lsu_resp_unexpected_o,
                   bus2.dummy_instr_wb_o};
    assign obs3 = {bus3.ready_wb_o, bus3.rf_we_wb_o, bus3.rf_waddr_wb_o, bus3.rf_wdata_wb_o,
                   bus3.fwd_a_valid_o, bus3.fwd_a_data_o, bus3.stall_a_o, bus3.fwd_b_valid_o,
                   bus3.fwd_b_data_o, bus3.stall_b_o, bus3.outstanding_load_wb_o,
                   bus3.outstanding_store_wb_o, 2'b00, bus3.occupancy_o, bus3.pc_wb_o,
                   bus3.instr_done_wb_o, bus3.perf_instr_ret_wb_o,
                   bus3.perf_instr_ret_compressed_wb_o, bus3.lsu_resp_unexpected_o,
                   bus3.dummy_instr_wb_o};

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  typ;
        logic [31:0] pc;
        logic        comp, cnt, dmy;
    } ent_t;

    ent_t   q2[$];
    ent_t   q3[$];
    bit     track = 0;
    logic [31:0] retired[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Youngest valid writer of raddr decides: a LOAD stalls, anything else forwards.
    task automatic hazard(input ent_t q[$], input logic [4:0] r,
                          output bit fv, output logic [31:0] fd, output bit st);
        fv = 0; fd = 0; st = 0;
        if (r != 0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].waddr == r && (q[i].we || q[i].typ == WB_INSTR_LOAD)) begin
                    if (q[i].typ == WB_INSTR_LOAD) st = 1;
                    else begin fv = 1; fd = q[i].wdata; end
                    break;
                end
            end
        end
    endtask

    task automatic eval(input string nm, input int depth, input ent_t q[$], input obs_t o,
                        output bit done, output bit acc);
        ent_t h;
        bit hv, we_id, we_lsu, perf, unexp, ol, os, fav, sa, fbv, sb, rdy;
        logic [31:0] wd, fad, fbd;
        hv = (q.size() != 0);
        h = hv ? q[0] : '0;
        done = hv && (h.typ == WB_INSTR_OTHER || resp);
        rdy = (q.size() < depth) || done;
        acc = en && rdy;
        we_id = hv && h.we && h.typ == WB_INSTR_OTHER;
        we_lsu = hv && h.typ == WB_INSTR_LOAD && lsu_we;
        wd = we_id ? h.wdata : (we_lsu ? lsu_data : 32'h0);
        perf = done && h.cnt && !(resp && err);
`ifdef IBEX_WB_QUEUE_DUMMY_EN
        perf = perf && !h.dmy;
        check({nm, ".dummy"}, o.dummy, hv && h.dmy);
`else
        check({nm, ".dummy"}, o.dummy, 0);
`endif
        unexp = resp && !(hv && h.typ != WB_INSTR_OTHER);
        ol = 0; os = 0;
        foreach (q[i]) begin
            if (q[i].typ == WB_INSTR_LOAD) ol = 1;
            if (q[i].typ == WB_INSTR_STORE) os = 1;
        end
        hazard(q, ra, fav, fad, sa);
        hazard(q, rb, fbv, fbd, sb);
        check({nm, ".ready"}, o.ready, rdy);
        check({nm, ".rf_we"}, o.we, we_id || we_lsu);
        check({nm, ".rf_wdata"}, o.wdata, wd);
        if (hv) begin
            check({nm, ".rf_waddr"}, o.waddr, h.waddr);
            check({nm, ".pc"}, o.pc, h.pc);
        end
        check({nm, ".done"}, o.done, done);
        check({nm, ".perf"}, o.perf, perf);
        check({nm, ".perfc"}, o.perfc, perf && h.comp);
        check({nm, ".unexp"}, o.unexp, unexp);
        check({nm, ".occ"}, o.occ, q.size());
        check({nm, ".out_ld"}, o.ol, ol);
        check({nm, ".out_st"}, o.os, os);
        check({nm, ".fwd_a_v"}, o.fav, fav);
        check({nm, ".fwd_a_d"}, o.fad, fad);
        check({nm, ".stall_a"}, o.sa, sa);
        check({nm, ".fwd_b_v"}, o.fbv, fbv);
        check({nm, ".fwd_b_d"}, o.fbd, fbd);
        check({nm, ".stall_b"}, o.sb, sb);
    endtask

    // Inputs are set after a falling edge; check, then advance the model on the rising edge.
    task automatic cycle();
        bit d2, a2, d3, a3;
        ent_t e;
        #1;
        eval("d2", 2, q2, obs2, d2, a2);
        eval("d3", 3, q3, obs3, d3, a3);
        e.we = we; e.waddr = waddr; e.wdata = wdata; e.typ = itype; e.pc = pc;
        e.comp = comp; e.cnt = cnt; e.dmy = dmy;
        if (track && d3) retired.push_back(q3[0].pc);
        @(posedge clk);
        if (d2) q2.delete(0);
        if (a2) q2.push_back(e);
        if (d3) q3.delete(0);
        if (a3) q3.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        en = 0; itype = WB_INSTR_OTHER; pc = 0; comp = 0; cnt = 0; waddr = 0; wdata = 0;
        we = 0; dmy = 0; ra = 0; rb = 0; lsu_data = 0; lsu_we = 0; resp = 0; err = 0;
    endtask

    task automatic offer(input wb_instr_type_e t, input logic [4:0] a, input logic [31:0] d,
                         input logic w, input logic [31:0] p);
        idle();
        en = 1; itype = t; waddr = a; wdata = d; we = w; pc = p; cnt = 1; comp = 1;
    endtask

    task automatic rand_inputs();
        en = 1'($urandom_range(0, 1));
        itype = wb_instr_type_e'($urandom_range(0, 2));
        pc = $urandom & 32'hFFFF_FFFC;
        comp = 1'($urandom_range(0, 1));
        cnt = 1'($urandom_range(0, 1));
        waddr = 5'($urandom_range(0, 7));
        wdata = $urandom;
        we = 1'($urandom_range(0, 1));
        dmy = 1'($urandom_range(0, 1));
        ra = 5'($urandom_range(0, 7));
        rb = 5'($urandom_range(0, 7));
        lsu_data = $urandom;
        lsu_we = 1'($urandom_range(0, 1));
        resp = ($urandom_range(0, 9) < 4);
        err = ($urandom_range(0, 3) == 0);
    endtask

    initial begin
        idle();
        rst_n = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst.occ", obs2.occ, 0);
        check("rst.ready", obs2.ready, 1);
        rst_n = 1;
        @(negedge clk);
        #1;
        check("idle.pc", obs2.pc, 0);
        check("idle.waddr", obs2.waddr, 0);
        check("idle.rf_we", obs3.we, 0);
        cycle();

        // Single OTHER retires the cycle after acceptance.
        offer(WB_INSTR_OTHER, 5'd5, 32'h11, 1, 32'h100);
        cycle();
        idle();
        #1;
        check("t1.rf_we", obs2.we, 1);
        check("t1.waddr", obs2.waddr, 5);
        check("t1.wdata", obs2.wdata, 32'h11);
        check("t1.done", obs2.done, 1);
        cycle();
        #1 check("t1.occ", obs2.occ, 0);
        cycle();

        // Full Depth=2 queue accepts while its LOAD head retires.
        offer(WB_INSTR_LOAD, 5'd3, 0, 1, 32'h200);
        cycle();
        offer(WB_INSTR_OTHER, 5'd4, 32'h22, 1, 32'h204);
        cycle();
        idle();
        #1;
        check("t2.occ", obs2.occ, 2);
        check("t2.ready", obs2.ready, 0);
        offer(WB_INSTR_OTHER, 5'd6, 32'h33, 1, 32'h208);
        resp = 1; lsu_we = 1; lsu_data = 32'hAB;
        #1;
        check("t2.lsu_we", obs2.we, 1);
        check("t2.lsu_waddr", obs2.waddr, 3);
        check("t2.lsu_wdata", obs2.wdata, 32'hAB);
        check("t2.ready_full", obs2.ready, 1);
        cycle();
        idle();
        #1 check("t2.occ_keep", obs2.occ, 2);
        repeat (3) cycle();

        // Younger OTHER shadows an older LOAD of the same register.
        offer(WB_INSTR_LOAD, 5'd7, 0, 1, 32'h300);
        cycle();
        offer(WB_INSTR_OTHER, 5'd7, 32'h55, 1, 32'h304);
        cycle();
        idle();
        ra = 7;
        #1;
        check("t3.fwd_v", obs2.fav, 1);
        check("t3.fwd_d", obs2.fad, 32'h55);
        check("t3.stall", obs2.sa, 0);
        cycle();
        ra = 0;
        #1;
        check("t3.r0_fwd", obs2.fav, 0);
        check("t3.r0_stall", obs2.sa, 0);
        cycle();
        resp = 1; lsu_we = 1;
        cycle();
        idle();
        repeat (2) cycle();

        // Younger LOAD behind an older OTHER (held by a blocked STORE head).
        offer(WB_INSTR_STORE, 5'd0, 0, 0, 32'h400);
        cycle();
        offer(WB_INSTR_OTHER, 5'd7, 32'h55, 1, 32'h404);
        cycle();
        offer(WB_INSTR_LOAD, 5'd7, 0, 1, 32'h408);
        cycle();
        idle();
        ra = 7;
        #1;
        check("t4.stall", obs3.sa, 1);
        check("t4.fwd_v", obs3.fav, 0);
        cycle();
        ra = 0;
        #1 check("t4.r0_stall", obs3.sa, 0);
        resp = 1; lsu_we = 1;
        repeat (3) cycle();
        idle();
        repeat (2) cycle();

        // Store error response retires without counting; response on empty queue.
        offer(WB_INSTR_STORE, 5'd0, 0, 0, 32'h500);
        cycle();
        idle();
        resp = 1; err = 1;
        #1;
        check("t5.done", obs2.done, 1);
        check("t5.perf", obs2.perf, 0);
        cycle();
        idle();
        resp = 1;
        #1 check("t5.unexp", obs3.unexp, 1);
        cycle();
        idle();
        #1 check("t5.unexp_end", obs3.unexp, 0);
        cycle();

        // Back-to-back OTHERs wrap the Depth=3 pointers.
        track = 1;
        for (int i = 0; i < 10; i++) begin
            offer(WB_INSTR_OTHER, 5'(i + 1), 32'(i), 1, 32'(4 * i));
            cycle();
        end
        idle();
        repeat (2) cycle();
        track = 0;
        check("t6.n_ret", retired.size(), 10);
        for (int i = 0; i < 10 && i < retired.size(); i++) begin
            check($sformatf("t6.ret_pc%0d", i), retired[i], 32'(4 * i));
        end

        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            cycle();
        end

        // Asynchronous reset mid-stream.
        rand_inputs();
        resp = 1; lsu_we = 1;
        rst_n = 0;
        #1;
        check("t7.occ2", obs2.occ, 0);
        check("t7.occ3", obs3.occ, 0);
        check("t7.rf_we2", obs2.we, 0);
        check("t7.rf_we3", obs3.we, 0);
        q2.delete();
        q3.delete();
        @(negedge clk);
        rst_n = 1;
        idle();
        cycle();
        for (int i = 0; i < 150; i++) begin
            rand_inputs();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ibex_wb_queue.md
Name: ibex_wb_queue

Overview:
Multi-entry writeback stage that sits between ID/EX and the register file. It holds up to Depth in-flight instructions and retires them strictly in order from the head. Loads and stores wait at the head for their LSU response; other instructions retire in one cycle. It gives ID/EX per-operand forwarding and stall information across all occupied entries, so several loads and stores can be outstanding at once.

Parameters:
Depth, 2, number of writeback entries; legal range 1..8; Depth=1 matches a single-entry writeback stage.
PtrW, derived $clog2(Depth) (min 1), width of the head and tail pointers; not overridable.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset: asynchronous assert, active-low; all state registers are reset by it
en_wb_i  in  1  ID/EX offers an instruction this cycle
instr_type_wb_i  in  wb_instr_type_e  WB_INSTR_LOAD, WB_INSTR_STORE or WB_INSTR_OTHER
pc_id_i  in  32  PC of the offered instruction
instr_is_compressed_id_i  in  1  offered instruction is compressed
instr_perf_count_id_i  in  1  offered instruction counts toward retire counters
rf_waddr_id_i  in  5  destination register
rf_wdata_id_i  in  32  result from ID/EX
rf_we_id_i  in  1  ID/EX result writes the RF
dummy_instr_id_i  in  1  offered instruction is a dummy (used only with the optional feature)
rf_raddr_a_i, rf_raddr_b_i  in  5 each  ID operand addresses for the hazard check
rf_wdata_lsu_i  in  32  load data
rf_we_lsu_i  in  1  LSU requests an RF write
lsu_resp_valid_i  in  1  LSU response for the oldest load/store
lsu_resp_err_i  in  1  that response carries an error
ready_wb_o  out  1  an offered instruction is accepted
rf_waddr_wb_o  out  5  RF write address (head entry)
rf_wdata_wb_o  out  32  RF write data
rf_we_wb_o  out  1  RF write enable
fwd_a_valid_o, fwd_b_valid_o  out  1 each  forwarded data available for operand A / B
fwd_a_data_o, fwd_b_data_o  out  32 each  forwarded data for operand A / B
stall_a_o, stall_b_o  out  1 each  operand A / B depends on an unresolved load
outstanding_load_wb_o  out  1  at least one valid LOAD entry
outstanding_store_wb_o  out  1  at least one valid STORE entry
occupancy_o  out  $clog2(Depth+1)  number of valid entries
pc_wb_o  out  32  head PC
instr_done_wb_o  out  1  head retires this cycle
perf_instr_ret_wb_o  out  1  retire counter increment
perf_instr_ret_compressed_wb_o  out  1  compressed retire counter increment
lsu_resp_unexpected_o  out  1  LSU response arrived with no load/store at the head
dummy_instr_wb_o  out  1  head entry is a dummy instruction

Behaviour:
- Storage: circular buffer. Each entry holds {we, waddr, wdata, type, pc, compressed, count, dummy}.
- Pointers: head, tail and count registers. Pointers wrap at Depth-1 to 0, including non-power-of-2 Depth.
- Reset values: count=0, head=tail=0, ready_wb_o=1. Every other output is 0. Entry payloads are reset to 0.
- Head done: head_done = head_valid & (type==OTHER | lsu_resp_valid_i).
  - A response is consumed only when the head is LOAD or STORE.
- Retire: instr_done_wb_o = head_done. On retire, head advances in the same cycle.
- Accept: ready_wb_o = (count<Depth) | head_done.
  - Accept = en_wb_i & ready_wb_o. The entry is written at tail on the next clock edge.
  - A simultaneous accept and retire leaves count unchanged; this is legal even when the buffer is full.
  - en_wb_i while not ready: the offer is ignored and no state changes.
- RF write from ID data: we_id_path = head_valid & head.we & head.type==OTHER.
- RF write from LSU data: we_lsu_path = head_valid & head.type==LOAD & rf_we_lsu_i.
- RF write outputs:
  - rf_we_wb_o = we_id_path | we_lsu_path.
  - rf_wdata_wb_o is the AND-OR mux of the two paths.
  - rf_waddr_wb_o = head.waddr.
- Empty queue: with no valid entries, rf_we_wb_o=0 even if rf_we_lsu_i=1.
- Hazard check, per operand, with raddr != 0:
  - Scan the valid entries from youngest to oldest for waddr==raddr where (we | type==LOAD).
  - Youngest match is LOAD: stall=1, fwd_valid=0.
  - Youngest match is non-LOAD with we=1: fwd_valid=1, fwd_data=entry.wdata, stall=0.
  - No match, or raddr==0: all three are 0.
  - The check is combinational on current state only. An instruction accepted in the same cycle is not visible.
- Perf counters:
  - perf_instr_ret_wb_o = head_done & head.count & ~(lsu_resp_valid_i & lsu_resp_err_i).
  - perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o & head.compressed.
- Unexpected response: lsu_resp_unexpected_o = lsu_resp_valid_i & ~(head_valid & head.type!=OTHER). It is a single-cycle pulse and has no other effect.
- Reset mid-operation: all entries are discarded immediately. Outputs return to reset values asynchronously.

Optional Feature:
Macro: IBEX_WB_QUEUE_DUMMY_EN.
- Defined: the dummy bit is stored per entry and dummy_instr_wb_o = head_valid & head.dummy. A dummy head forces perf_instr_ret_wb_o and perf_instr_ret_compressed_wb_o to 0.
- Undefined: there is no dummy storage, dummy_instr_id_i is ignored and dummy_instr_wb_o is tied to 0.

Test Plan:
- Reset, then idle -> ready_wb_o=1, occupancy_o=0, rf_we_wb_o=0; all other outputs 0.
- Depth=2: accept OTHER (x5, 0x11) in cycle 0 -> cycle 1 gives rf_we_wb_o=1, rf_waddr_wb_o=5, rf_wdata_wb_o=0x11, instr_done_wb_o=1, occupancy back to 0 in cycle 2.
- Depth=2: accept LOAD x3, then OTHER x4=0x22, no response -> occupancy_o=2, ready_wb_o=0. Offer a third instruction while lsu_resp_valid_i=1, rf_we_lsu_i=1, data 0xAB -> x3 written with 0xAB, third instruction accepted, occupancy_o stays 2.
- Queue holds LOAD x7 (older) and OTHER x7=0x55 (younger), rf_raddr_a_i=7 -> fwd_a_valid_o=1, fwd_a_data_o=0x55, stall_a_o=0. Swap the age order -> stall_a_o=1, fwd_a_valid_o=0. rf_raddr_a_i=0 -> all 0.
- Head STORE with count=1: response with lsu_resp_err_i=1 -> instr_done_wb_o=1, perf_instr_ret_wb_o=0. lsu_resp_valid_i with the queue empty -> lsu_resp_unexpected_o=1 for exactly 1 cycle.
- Depth=3: run 10 back-to-back OTHER instructions -> pointer wrap-around is exercised, retire order matches PCs 0x0,0x4,...,0x24. Drop rst_ni mid-stream -> occupancy_o=0 immediately, no RF write afterwards.
